// File: rtl/kitchen_timer_ctrl.sv
// rtl/kitchen_timer_ctrl.sv - kitchen timer countdown FSM with BCD MM:SS and seven-segment outputs
module kitchen_timer_ctrl #(
  parameter int unsigned TICK_DIV  = 100_000_000,
  parameter int unsigned BLINK_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start,
  input  logic       btn_clear,
  input  logic       btn_min,
  input  logic       btn_sec,
  output logic [7:0] seg_m1,
  output logic [7:0] seg_m0,
  output logic [7:0] seg_s1,
  output logic [7:0] seg_s0,
  output logic       alarm,
  output logic [1:0] state
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_ALARM = 2'b11
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    m1_q, m0_q, s1_q, s0_q;
  logic [3:0]    m1_d, m0_d, s1_d, s0_d;
  logic [TW-1:0] presc_q, presc_d;
  logic [BW-1:0] blink_cnt_q;
  logic          blink_on_q;
  logic [7:0]    seg_m1_q, seg_m0_q, seg_s1_q, seg_s0_q;
  logic [7:0]    seg_m1_d, seg_m0_d, seg_s1_d, seg_s0_d;
  logic          tick, time_zero, last_sec, show, dp;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'h3F;
      4'd1:    seg7 = 8'h06;
      4'd2:    seg7 = 8'h5B;
      4'd3:    seg7 = 8'h4F;
      4'd4:    seg7 = 8'h66;
      4'd5:    seg7 = 8'h6D;
      4'd6:    seg7 = 8'h7D;
      4'd7:    seg7 = 8'h07;
      4'd8:    seg7 = 8'h7F;
      4'd9:    seg7 = 8'h6F;
      default: seg7 = 8'h00;
    endcase
  endfunction

  assign tick      = (state_q == ST_RUN) && (presc_q == TICK_LAST);
  assign time_zero = ({m1_q, m0_q, s1_q, s0_q} == 16'h0000);
  assign last_sec  = ({m1_q, m0_q, s1_q, s0_q} == 16'h0001);

  always_comb begin
    state_d = state_q;
    m1_d    = m1_q;
    m0_d    = m0_q;
    s1_d    = s1_q;
    s0_d    = s0_q;
    presc_d = presc_q;
    if (btn_clear) begin
      state_d = ST_IDLE;
      m1_d    = 4'd0;
      m0_d    = 4'd0;
      s1_d    = 4'd0;
      s0_d    = 4'd0;
      presc_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (btn_start) begin
            if (!time_zero) begin
              state_d = ST_RUN;
              presc_d = '0;
            end
          end else begin
            if (btn_min) begin
              if (m0_q == 4'd9) begin
                m0_d = 4'd0;
                m1_d = (m1_q == 4'd9) ? 4'd0 : m1_q + 4'd1;
              end else begin
                m0_d = m0_q + 4'd1;
              end
            end
            if (btn_sec) begin
              if (s0_q == 4'd9) begin
                s0_d = 4'd0;
                s1_d = (s1_q == 4'd5) ? 4'd0 : s1_q + 4'd1;
              end else begin
                s0_d = s0_q + 4'd1;
              end
            end
          end
        end
        ST_RUN: begin
          presc_d = tick ? '0 : presc_q + 1'b1;
          // Borrow chain s0 -> s1 -> m0 -> m1; never underflows since 00:01 ends in ALARM.
          if (tick) begin
            if (s0_q != 4'd0) begin
              s0_d = s0_q - 4'd1;
            end else begin
              s0_d = 4'd9;
              if (s1_q != 4'd0) begin
                s1_d = s1_q - 4'd1;
              end else begin
                s1_d = 4'd5;
                if (m0_q != 4'd0) begin
                  m0_d = m0_q - 4'd1;
                end else begin
                  m0_d = 4'd9;
                  m1_d = m1_q - 4'd1;
                end
              end
            end
          end
          if (tick && last_sec) state_d = ST_ALARM;
          else if (btn_start)   state_d = ST_PAUSE;
        end
        ST_PAUSE: if (btn_start) state_d = ST_RUN;
        ST_ALARM: if (btn_start) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    show     = !((state_q == ST_ALARM) && !blink_on_q);
    dp       = (state_q == ST_PAUSE) ? blink_on_q : 1'b1;
    seg_m1_d = (show && (m1_q != 4'd0)) ? seg7(m1_q) : 8'h00;
    seg_m0_d = show ? (seg7(m0_q) | {dp, 7'b0}) : 8'h00;
    seg_s1_d = show ? seg7(s1_q) : 8'h00;
    seg_s0_d = show ? seg7(s0_q) : 8'h00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      m1_q        <= 4'd0;
      m0_q        <= 4'd0;
      s1_q        <= 4'd0;
      s0_q        <= 4'd0;
      presc_q     <= '0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      seg_m1_q    <= 8'h00;
      seg_m0_q    <= 8'h00;
      seg_s1_q    <= 8'h00;
      seg_s0_q    <= 8'h00;
    end else begin
      state_q  <= state_d;
      m1_q     <= m1_d;
      m0_q     <= m0_d;
      s1_q     <= s1_d;
      s0_q     <= s0_d;
      presc_q  <= presc_d;
      seg_m1_q <= seg_m1_d;
      seg_m0_q <= seg_m0_d;
      seg_s1_q <= seg_s1_d;
      seg_s0_q <= seg_s0_d;
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_q <= '0;
        blink_on_q  <= !blink_on_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end
    end
  end

  assign seg_m1 = seg_m1_q;
  assign seg_m0 = seg_m0_q;
  assign seg_s1 = seg_s1_q;
  assign seg_s0 = seg_s0_q;
  assign alarm  = (state_q == ST_ALARM);
  assign state  = state_q;

endmodule

// File: tb/tb_kitchen_timer_ctrl.sv
// tb/tb_kitchen_timer_ctrl.sv - self-checking bench for kitchen_timer_ctrl
module tb_kitchen_timer_ctrl;

  localparam int TD = 4;
  localparam int BD = 2;
  localparam logic [7:0] SEG [0:9] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                       8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_start = 1'b0, btn_clear = 1'b0, btn_min = 1'b0, btn_sec = 1'b0;
  logic [7:0] seg_m1, seg_m0, seg_s1, seg_s0;
  logic       alarm;
  logic [1:0] state;

  kitchen_timer_ctrl #(.TICK_DIV(TD), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_start(btn_start), .btn_clear(btn_clear), .btn_min(btn_min), .btn_sec(btn_sec),
    .seg_m1(seg_m1), .seg_m0(seg_m0), .seg_s1(seg_s1), .seg_s0(seg_s0),
    .alarm(alarm), .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: time kept as integer minutes/seconds, states as plain ints.
  int m_state, m_min, m_sec, m_elapsed, m_k;
  logic [7:0] e_m1, e_m0, e_s1, e_s0;

  typedef struct {
    logic       st, cl, mn, sc;
    logic [1:0] exp_state;
    logic [7:0] exp_s0;
  } vec_t;
  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_min = 0; m_sec = 0; m_elapsed = 0; m_k = 0;
    e_m1 = 8'h00; e_m0 = 8'h00; e_s1 = 8'h00; e_s0 = 8'h00;
  endtask

  task automatic model_edge(input logic st, input logic cl, input logic mn, input logic sc);
    bit blink, show, dp, tick;
    int tot;
    blink = ((m_k / BD) % 2) == 0;
    show  = !(m_state == 3 && !blink);
    dp    = (m_state == 2) ? blink : 1'b1;
    e_m1  = (show && (m_min / 10) != 0) ? SEG[m_min / 10] : 8'h00;
    e_m0  = show ? (SEG[m_min % 10] | {dp, 7'b0}) : 8'h00;
    e_s1  = show ? SEG[m_sec / 10] : 8'h00;
    e_s0  = show ? SEG[m_sec % 10] : 8'h00;
    m_k++;
    if (cl) begin
      m_state = 0; m_min = 0; m_sec = 0; m_elapsed = 0;
    end else begin
      case (m_state)
        0: begin
          if (st) begin
            if (m_min != 0 || m_sec != 0) begin m_state = 1; m_elapsed = 0; end
          end else begin
            if (mn) m_min = (m_min + 1) % 100;
            if (sc) m_sec = (m_sec + 1) % 60;
          end
        end
        1: begin
          tick = (m_elapsed % TD) == TD - 1;
          m_elapsed++;
          if (tick) begin
            tot = m_min * 60 + m_sec - 1;
            m_min = tot / 60;
            m_sec = tot % 60;
          end
          if (tick && m_min == 0 && m_sec == 0) m_state = 3;
          else if (st) m_state = 2;
        end
        2: if (st) m_state = 1;
        default: if (st) m_state = 0;
      endcase
    end
  endtask

  task automatic do_edge(input logic st, input logic cl, input logic mn, input logic sc);
    @(negedge clk);
    btn_start = st; btn_clear = cl; btn_min = mn; btn_sec = sc;
    @(posedge clk);
    model_edge(st, cl, mn, sc);
    #1;
    btn_start = 1'b0; btn_clear = 1'b0; btn_min = 1'b0; btn_sec = 1'b0;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_state"}, 32'(state), 32'(m_state));
    chk({tag, "_alarm"}, 32'(alarm), 32'(m_state == 3));
    chk({tag, "_seg_m1"}, 32'(seg_m1), 32'(e_m1));
    chk({tag, "_seg_m0"}, 32'(seg_m0), 32'(e_m0));
    chk({tag, "_seg_s1"}, 32'(seg_s1), 32'(e_s1));
    chk({tag, "_seg_s0"}, 32'(seg_s0), 32'(e_s0));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"}, 32'(state), 32'd0);
    chk({tag, "_alarm"}, 32'(alarm), 32'd0);
    chk({tag, "_seg_m1"}, 32'(seg_m1), 32'h00);
    chk({tag, "_seg_m0"}, 32'(seg_m0), 32'h00);
    chk({tag, "_seg_s1"}, 32'(seg_s1), 32'h00);
    chk({tag, "_seg_s0"}, 32'(seg_s0), 32'h00);
  endtask

  initial begin
    bit seen0, seen1;
    logic st, cl, mn, sc;

    // {start, clear, min, sec, state after edge, seg_s0 after edge}
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 8'h3F};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 8'h06};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'h5B};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 8'h5B};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 8'h5B};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 8'h5B};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 8'h5B};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 8'h5B};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 8'h06};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 8'h06};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 8'h06};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'h06};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h3F};

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("in_reset");
    rst_n = 1'b1;
    chk("rel_state", 32'(state), 32'd0);
    chk("rel_alarm", 32'(alarm), 32'd0);
    do_edge(0, 0, 0, 0);
    chk("rel_seg_m1", 32'(seg_m1), 32'h00);
    chk("rel_seg_m0", 32'(seg_m0), 32'hBF);
    chk("rel_seg_s1", 32'(seg_s1), 32'h3F);
    chk("rel_seg_s0", 32'(seg_s0), 32'h3F);

    repeat (61) do_edge(0, 0, 0, 1);
    do_edge(0, 0, 0, 0);
    chk("sec61_s1", 32'(seg_s1), 32'h3F);
    chk("sec61_s0", 32'(seg_s0), 32'h06);
    repeat (100) do_edge(0, 0, 1, 0);
    do_edge(0, 0, 0, 0);
    chk("min100_m1", 32'(seg_m1), 32'h00);
    chk("min100_m0", 32'(seg_m0), 32'hBF);
    do_edge(0, 1, 0, 0);
    do_edge(1, 0, 0, 0);
    chk("start_zero_state", 32'(state), 32'd0);

    for (int i = 0; i < 13; i++) begin
      do_edge(tbl[i].st, tbl[i].cl, tbl[i].mn, tbl[i].sc);
      chk($sformatf("tbl%0d_state", i), 32'(state), 32'(tbl[i].exp_state));
      chk($sformatf("tbl%0d_alarm", i), 32'(alarm), 32'd0);
      chk($sformatf("tbl%0d_seg_s0", i), 32'(seg_s0), 32'(tbl[i].exp_s0));
    end

    do_edge(0, 1, 0, 0);
    do_edge(0, 0, 1, 0);
    do_edge(1, 0, 0, 0);
    chk("run_state", 32'(state), 32'd1);
    repeat (3) do_edge(0, 0, 0, 0);
    chk("pretick_state", 32'(state), 32'd1);
    repeat (2) do_edge(0, 0, 0, 0);
    chk("t059_m1", 32'(seg_m1), 32'h00);
    chk("t059_m0", 32'(seg_m0), 32'hBF);
    chk("t059_s1", 32'(seg_s1), 32'h6D);
    chk("t059_s0", 32'(seg_s0), 32'h6F);

    do_edge(0, 1, 0, 0);
    repeat (2) do_edge(0, 0, 0, 1);
    do_edge(1, 0, 0, 0);
    repeat (7) do_edge(0, 0, 0, 0);
    chk("prealarm_state", 32'(state), 32'd1);
    do_edge(0, 0, 0, 0);
    chk("alarm_state", 32'(state), 32'd3);
    chk("alarm_out", 32'(alarm), 32'd1);
    seen0 = 0; seen1 = 0;
    for (int i = 0; i < 8; i++) begin
      do_edge(0, 0, 0, 0);
      chk_model("alarm_blink");
      if (seg_s0 == 8'h00) seen0 = 1;
      if (seg_s0 == 8'h3F) seen1 = 1;
    end
    chk("alarm_blink_both", 32'({seen0, seen1}), 32'b11);
    do_edge(1, 0, 0, 0);
    chk("ack_state", 32'(state), 32'd0);
    chk("ack_alarm", 32'(alarm), 32'd0);
    do_edge(0, 0, 0, 0);
    chk("ack_s0", 32'(seg_s0), 32'h3F);
    chk("ack_m0", 32'(seg_m0), 32'hBF);

    do_edge(0, 1, 0, 0);
    repeat (5) do_edge(0, 0, 0, 1);
    do_edge(1, 0, 0, 0);
    do_edge(0, 0, 0, 0);
    do_edge(1, 0, 0, 0);
    chk("pause_state", 32'(state), 32'd2);
    seen0 = 0; seen1 = 0;
    for (int i = 0; i < 20; i++) begin
      do_edge(0, 0, 0, 0);
      chk("pause_hold_s0", 32'(seg_s0), 32'h6D);
      if (seg_m0[7]) seen1 = 1; else seen0 = 1;
    end
    chk("pause_dp_toggle", 32'({seen0, seen1}), 32'b11);
    do_edge(1, 0, 0, 0);
    chk("resume_state", 32'(state), 32'd1);
    do_edge(0, 0, 0, 0);
    do_edge(0, 0, 0, 0);
    chk("resume_notick_s0", 32'(seg_s0), 32'h6D);
    do_edge(0, 0, 0, 0);
    chk("resume_tick_s0", 32'(seg_s0), 32'h66);

    do_edge(0, 1, 0, 0);
    repeat (3) do_edge(0, 0, 0, 1);
    do_edge(1, 0, 0, 0);
    do_edge(0, 0, 0, 0);
    do_edge(1, 1, 0, 0);
    chk("clr_start_state", 32'(state), 32'd0);
    do_edge(0, 0, 0, 0);
    chk("clr_start_s0", 32'(seg_s0), 32'h3F);
    do_edge(0, 0, 0, 1);
    do_edge(1, 0, 0, 0);
    repeat (2) do_edge(0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("midrun_reset");
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    do_edge(0, 0, 0, 0);
    chk_model("post_reset");

    for (int i = 0; i < 3000; i++) begin
      st = ($urandom_range(0, 7) == 0);
      cl = ($urandom_range(0, 63) == 0);
      mn = ($urandom_range(0, 15) == 0);
      sc = ($urandom_range(0, 3) == 0);
      do_edge(st, cl, mn, sc);
      chk_model("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
